uart_receiver: RTL and testbench

//  Downstream counterpart of the board UART transmitter: deserialises 8N1 frames from i_rx
//  (idle-high line, LSB first) into bytes, with a one-deep valid/ready output holding register.

---
 rtl/uart_receiver_pkg.sv | 16 +
 rtl/uart_receiver_sync_2ff.sv | 25 ++
 rtl/uart_receiver.sv | 134 +++++++++++++
 tb/tb_uart_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: clocking constants and receiver state encoding.
package uart_receiver_pkg;

  localparam int UART_CLK_HZ          = 12_000_000;
  localparam int UART_BAUD            = 115_200;
  localparam int DEFAULT_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input; resets to the idle-high value.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  // Shift the raw input through two flops; both park high in reset so the line looks idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: bit-period counter sampling at bit centres, one-deep valid/ready holding register.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            rx_s;
  rx_state_e       state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic [7:0]      data_reg;
  logic            valid_reg;
  logic            busy_reg;
  logic            ferr_reg;
  logic            ovr_reg;

  sync_2ff u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_rx),
    .q     (rx_s)
  );

  // Frame FSM plus output holding register; the delivery branch overrides a same-cycle accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      ferr_reg <= 1'b0;
      ovr_reg  <= 1'b0;
      if (valid_reg && i_ready) begin
        valid_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (!rx_s) begin
            state_reg <= ST_START;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_reg == HALF_M1) begin
            if (!rx_s) begin
              state_reg   <= ST_DATA;
              cnt_reg     <= '0;
              bit_idx_reg <= '0;
            end else begin
              // Start bit vanished before its centre: treat as a glitch.
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_reg == FULL_M1) begin
            shift_reg   <= {rx_s, shift_reg[7:1]};
            cnt_reg     <= '0;
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              if (!valid_reg || i_ready) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
              end else begin
                ovr_reg <= 1'b1;
              end
            end else begin
              ferr_reg  <= 1'b1;
              state_reg <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low line reports one error, then waits for the line to recover.
          if (rx_s) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_busy      = busy_reg;
  assign o_frame_err = ferr_reg;
  assign o_overrun   = ovr_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver; expected bytes/pulses come from a frame-level model.
module tb_uart_receiver;

  localparam int N   = 104;
  localparam int LAT = 2 + N / 2 + 9 * N;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       ferr;
  logic       ovr;

  uart_receiver #(.CLKS_PER_BIT(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_busy      (busy),
    .o_frame_err (ferr),
    .o_overrun   (ovr)
  );

  always #5 clk = ~clk;

  // Observation side: cycle count, pulse counters and the log of accepted bytes.
  int         cyc       = 0;
  int         rise_cyc  = -1;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         valid_cyc = 0;
  int         busy_cyc  = 0;
  int         got_n     = 0;
  logic       prev_v    = 1'b0;
  logic [7:0] got [256];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    prev_v <= valid;
    if (valid && !prev_v) rise_cyc <= cyc;
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (valid) valid_cyc <= valid_cyc + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (valid && ready && rst_n && got_n < 256) begin
      got[got_n] <= data;
      got_n      <= got_n + 1;
    end
  end

  // Reference model state: bytes the consumer should have taken, in order.
  logic [7:0] exp_bytes [256];
  int         exp_n  = 0;
  int         rd_i   = 0;
  int         passed = 0;
  int         total  = 0;
  int         last_start = 0;

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, expv, expv);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_bytes[exp_n] = b;
    exp_n++;
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_n, exp_n);
    for (int i = rd_i; i < exp_n && i < got_n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), int'(got[i]), int'(exp_bytes[i]));
    end
    rd_i = exp_n;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from the current negedge; a low stop bit is held for one extra bit time.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    $display("frame tx data=0x%02h stop=%0d cyc=%0d", b, stop, cyc + 1);
    rx = 1'b0;
    last_start = cyc + 1;
    idle(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(N);
    end
    rx = stop;
    idle(N);
    if (!stop) begin
      idle(N);
      rx = 1'b1;
      idle(N);
    end
    rx = 1'b1;
  endtask

  int         f0, o0, v0, b0, s1;
  logic [7:0] r;
  logic       st;

  initial begin
    idle(4);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    idle(3 * N);

    // Single frame, consumer always ready: exact latency and a one-cycle valid.
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cyc;
    send_frame(8'hA5, 1'b1);
    idle(2 * N);
    check("t1_latency", rise_cyc - last_start, LAT);
    check("t1_valid_cycles", valid_cyc - v0, 1);
    check("t1_ferr", ferr_cnt - f0, 0);
    check("t1_ovr", ovr_cnt - o0, 0);
    expect_byte(8'hA5);
    check_bytes("t1");

    // Short low glitch on an idle line.
    f0 = ferr_cnt; v0 = valid_cyc; b0 = busy_cyc;
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(2 * N);
    check("t2_busy_seen", int'(busy_cyc > b0), 1);
    check("t2_busy_now", busy, 0);
    check("t2_valid_cycles", valid_cyc - v0, 0);
    check("t2_ferr", ferr_cnt - f0, 0);

    // Bad stop bit, then a good frame.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    idle(N);
    check("t3_ferr", ferr_cnt - f0, 1);
    check_bytes("t3a");
    send_frame(8'h55, 1'b1);
    idle(2 * N);
    check("t3_ferr_after", ferr_cnt - f0, 1);
    expect_byte(8'h55);
    check_bytes("t3b");

    // Back-to-back frames with a stalled consumer: second byte is dropped.
    ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(N);
    check("t4_valid_held", valid, 1);
    check("t4_data_held", data, 8'h11);
    check("t4_ovr", ovr_cnt - o0, 1);
    ready = 1'b1;
    idle(1);
    check("t4_valid_drop", valid, 0);
    expect_byte(8'h11);
    check_bytes("t4");

    // Consumer becomes ready on exactly the cycle the second byte completes.
    ready = 1'b0;
    o0 = ovr_cnt;
    s1 = cyc + 1;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        while (cyc < s1 + 10 * N + LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("t5_valid", valid, 1);
        check("t5_data", data, 8'h22);
      end
    join
    idle(N);
    check("t5_ovr", ovr_cnt - o0, 0);
    ready = 1'b1;
    idle(2);
    expect_byte(8'h11);
    expect_byte(8'h22);
    check_bytes("t5");

    // Reset in the middle of a frame drops the held byte and the partial frame.
    ready = 1'b0;
    r = 8'($urandom_range(0, 255));
    f0 = ferr_cnt;
    send_frame(r, 1'b1);
    idle(N);
    check("t6_held_valid", valid, 1);
    check("t6_held_data", data, r);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        idle(4 * N + N / 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_data", data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ferr", ferr, 0);
        check("t6_rst_ovr", ovr, 0);
        rst_n = 1'b1;
      end
    join
    ready = 1'b1;
    idle(2 * N);
    send_frame(8'h0F, 1'b1);
    idle(2 * N);
    check("t6_ferr", ferr_cnt - f0, 0);
    expect_byte(8'h0F);
    check_bytes("t6");

    // Random bytes, random gaps, occasional bad stop bits.
    f0 = ferr_cnt;
    b0 = 0;
    for (int k = 0; k < 8; k++) begin
      r  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      idle($urandom_range(1, 3 * N));
      send_frame(r, st);
      if (st) expect_byte(r);
      else b0++;
    end
    idle(2 * N);
    check("t7_ferr", ferr_cnt - f0, b0);
    check_bytes("t7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
